// File: rtl/hash_result_serializer_if.sv
// Port bundle for the hash serializer.
// Capture side, beat stream and statistics.
interface hash_result_serializer_if #(
    parameter int DEPTH = 8,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             hash_valid_i;
    logic [127:0]     hash_i;
    logic             m_valid_o;
    logic [OUT_W-1:0] m_data_o;
    logic             m_last_o;
    logic             m_ready_i;
    logic [LW-1:0]    level_o;
    logic [CNT_W-1:0] hash_count_o;
    logic [CNT_W-1:0] drop_count_o;
    logic             overflow_o;

    modport master (
        output hash_valid_i,
        output hash_i,
        output m_ready_i,
        input  m_valid_o,
        input  m_data_o,
        input  m_last_o,
        input  level_o,
        input  hash_count_o,
        input  drop_count_o,
        input  overflow_o
    );

    modport slave (
        input  hash_valid_i,
        input  hash_i,
        input  m_ready_i,
        output m_valid_o,
        output m_data_o,
        output m_last_o,
        output level_o,
        output hash_count_o,
        output drop_count_o,
        output overflow_o
    );
endinterface

// File: rtl/hash_result_serializer.sv
// Buffers validated 128-bit hashes in a FIFO and streams
// them out MS word first on a valid/ready beat link.
module hash_result_serializer #(
    parameter int DEPTH = 8,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input logic                     clk,
    input logic                     rst,
    hash_result_serializer_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int BEATS = 128 / OUT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BW-1:0] BEAT_MAX = BW'(BEATS - 1);
    localparam logic [LW-1:0] FULL     = LW'(DEPTH);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                      state_q, state_d;
    logic [BW-1:0]               beat_q, beat_d;
    logic [127:0]                shift_q, shift_d;
    logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]               level_q, level_d;
    logic [CNT_W-1:0]            hash_cnt_q, drop_cnt_q;
    logic                        overflow_q;
    logic [127:0]                mem_q [DEPTH];
    logic                        pop, push, drop;
    logic                        done, xfer, last, valid;
    logic [BEATS-1:0][OUT_W-1:0] words;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        shift_d = shift_q;
        pop     = 1'b0;
        done    = 1'b0;
        last    = (beat_q == BEAT_MAX);
        xfer    = (state_q == SEND) && bus.m_ready_i;
        unique case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (last) begin
                        done = 1'b1;
                        // Reload straight from the FIFO so hashes
                        // stream without an idle bubble.
                        if (level_q != '0) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            beat_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
        endcase
    end

    // A pop frees a slot before the write lands, so full+pop accepts.
    assign push    = bus.hash_valid_i && ((level_q < FULL) || pop);
    assign drop    = bus.hash_valid_i && !push;
    assign level_d = level_q + LW'(push) - LW'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            hash_cnt_q <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            shift_q <= shift_d;
            level_q <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (done && !(&hash_cnt_q)) begin
                hash_cnt_q <= hash_cnt_q + CNT_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (!(&drop_cnt_q)) begin
                    drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.hash_i;
        end
    end

    assign words = shift_q;
    assign valid = (state_q == SEND);

    assign bus.m_valid_o    = valid;
    assign bus.m_last_o     = valid && last;
    assign bus.m_data_o     = valid ? words[BEAT_MAX - beat_q] : '0;
    assign bus.level_o      = level_q;
    assign bus.hash_count_o = hash_cnt_q;
    assign bus.drop_count_o = drop_cnt_q;
    assign bus.overflow_o   = overflow_q;
endmodule

// File: tb/tb_hash_result_serializer.sv
// Directed bench for hash_result_serializer: latency, order,
// backpressure, streaming, overflow and async reset.
module tb_hash_result_serializer;
    localparam int DEPTH = 8;
    localparam int OUT_W = 32;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hash_result_serializer_if #(
        .DEPTH(DEPTH), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) bus ();

    hash_result_serializer #(
        .DEPTH(DEPTH), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mkh(input int k);
        logic [31:0] b;
        b = 32'hA000_0000 | (32'(k) << 8);
        return {b, b | 32'd1, b | 32'd2, b | 32'd3};
    endfunction

    function automatic logic [31:0] xbeat(input logic [127:0] h, input int j);
        return h[127 - 32*j -: 32];
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        bus.hash_valid_i = 1'b0;
        bus.hash_i = '0;
        bus.m_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.hash_valid_i = 1'b0;
        bus.hash_i = '0;
        bus.m_ready_i = 1'b0;
        #12;
        checks++;
        if (bus.m_valid_o !== 1'b0 || bus.m_last_o !== 1'b0 || bus.m_data_o !== '0) begin
            errors++;
            $display("FAIL reset_stream valid=%b last=%b data=%h required 0/0/0",
                     bus.m_valid_o, bus.m_last_o, bus.m_data_o);
        end
        checks++;
        if (bus.level_o !== '0 || bus.hash_count_o !== '0 || bus.drop_count_o !== '0
            || bus.overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_stats level=%0d hc=%0d dc=%0d ovf=%b required all 0",
                     bus.level_o, bus.hash_count_o, bus.drop_count_o, bus.overflow_o);
        end
    endtask

    task automatic test_single();
        logic [31:0] exp [4];
        exp[0] = 32'h00112233;
        exp[1] = 32'h44556677;
        exp[2] = 32'h8899AABB;
        exp[3] = 32'hCCDDEEFF;
        do_reset();
        bus.m_ready_i = 1'b1;
        bus.hash_valid_i = 1'b1;
        bus.hash_i = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        @(negedge clk);
        bus.hash_valid_i = 1'b0;
        checks++;
        if (bus.m_valid_o !== 1'b0 || bus.level_o !== 4'd1) begin
            errors++;
            $display("FAIL t1_latency valid=%b level=%0d required valid=0 level=1",
                     bus.m_valid_o, bus.level_o);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== exp[k]
                || bus.m_last_o !== (k == 3)) begin
                errors++;
                $display("FAIL t1_beat%0d valid=%b data=%h last=%b required 1/%h/%b",
                         k, bus.m_valid_o, bus.m_data_o, bus.m_last_o, exp[k], k == 3);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.m_valid_o !== 1'b0 || bus.hash_count_o !== 16'd1) begin
            errors++;
            $display("FAIL t1_done valid=%b hc=%0d required 0/1",
                     bus.m_valid_o, bus.hash_count_o);
        end
    endtask

    task automatic test_backpressure();
        bit          pat [4];
        logic [127:0] h;
        logic [31:0] hold_d;
        logic        hold_l;
        bit          held;
        int          n;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        h = mkh(1);
        held = 1'b0;
        hold_d = '0;
        hold_l = 1'b0;
        n = 0;
        do_reset();
        bus.hash_valid_i = 1'b1;
        bus.hash_i = h;
        @(negedge clk);
        bus.hash_valid_i = 1'b0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (held) begin
                checks++;
                if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== hold_d
                    || bus.m_last_o !== hold_l) begin
                    errors++;
                    $display("FAIL t2_hold valid=%b data=%h last=%b required 1/%h/%b",
                             bus.m_valid_o, bus.m_data_o, bus.m_last_o, hold_d, hold_l);
                end
            end
            bus.m_ready_i = pat[c % 4];
            held = 1'b0;
            if (bus.m_valid_o === 1'b1) begin
                if (bus.m_ready_i) begin
                    checks++;
                    if (bus.m_data_o !== xbeat(h, n) || bus.m_last_o !== (n == 3)) begin
                        errors++;
                        $display("FAIL t2_beat%0d data=%h last=%b required %h/%b",
                                 n, bus.m_data_o, bus.m_last_o, xbeat(h, n), n == 3);
                    end
                    n++;
                end else begin
                    held = 1'b1;
                    hold_d = bus.m_data_o;
                    hold_l = bus.m_last_o;
                end
            end
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL t2_count beats=%0d required 4", n);
        end
        @(negedge clk);
        checks++;
        if (bus.m_valid_o !== 1'b0 || bus.hash_count_o !== 16'd1) begin
            errors++;
            $display("FAIL t2_done valid=%b hc=%0d required 0/1",
                     bus.m_valid_o, bus.hash_count_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] hs [3];
        logic [31:0]  gd [12];
        logic         gl [12];
        int first, lastc, n, lvmax;
        for (int i = 0; i < 3; i++) hs[i] = mkh(10 + i);
        first = -1; lastc = -1; n = 0; lvmax = 0;
        do_reset();
        bus.m_ready_i = 1'b1;
        for (int c = 0; c < 24; c++) begin
            bus.hash_valid_i = (c < 3);
            bus.hash_i = hs[(c < 3) ? c : 0];
            @(negedge clk);
            if (int'(bus.level_o) > lvmax) lvmax = int'(bus.level_o);
            if (bus.m_valid_o === 1'b1) begin
                if (first < 0) first = c;
                lastc = c;
                if (n < 12) begin
                    gd[n] = bus.m_data_o;
                    gl[n] = bus.m_last_o;
                end
                n++;
            end
        end
        checks++;
        if (n !== 12 || lastc - first !== 11) begin
            errors++;
            $display("FAIL t3_stream beats=%0d span=%0d required 12/11",
                     n, lastc - first);
        end
        checks++;
        if (lvmax !== 2) begin
            errors++;
            $display("FAIL t3_level peak=%0d required 2", lvmax);
        end
        for (int i = 0; i < 12 && i < n; i++) begin
            checks++;
            if (gd[i] !== xbeat(hs[i / 4], i % 4) || gl[i] !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL t3_beat%0d data=%h last=%b required %h/%b",
                         i, gd[i], gl[i], xbeat(hs[i / 4], i % 4), i % 4 == 3);
            end
        end
        checks++;
        if (bus.hash_count_o !== 16'd3) begin
            errors++;
            $display("FAIL t3_hcount hc=%0d required 3", bus.hash_count_o);
        end
    endtask

    task automatic drain(input int base, input int nbeats, input string tag);
        int n;
        n = 0;
        bus.m_ready_i = 1'b1;
        for (int c = 0; c < nbeats + 24 && n < nbeats; c++) begin
            if (bus.m_valid_o === 1'b1) begin
                checks++;
                if (bus.m_data_o !== xbeat(mkh(base + n / 4), n % 4)
                    || bus.m_last_o !== (n % 4 == 3)) begin
                    errors++;
                    $display("FAIL %s_beat%0d data=%h last=%b required %h/%b", tag, n,
                             bus.m_data_o, bus.m_last_o,
                             xbeat(mkh(base + n / 4), n % 4), n % 4 == 3);
                end
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n !== nbeats) begin
            errors++;
            $display("FAIL %s_count beats=%0d required %0d", tag, n, nbeats);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < 11; c++) begin
            bus.hash_valid_i = 1'b1;
            bus.hash_i = mkh(20 + c);
            @(negedge clk);
        end
        bus.hash_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.level_o !== 4'd8 || bus.drop_count_o !== 16'd2 || bus.overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL t4_full level=%0d dc=%0d ovf=%b required 8/2/1",
                     bus.level_o, bus.drop_count_o, bus.overflow_o);
        end
        checks++;
        if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== xbeat(mkh(20), 0)) begin
            errors++;
            $display("FAIL t4_head valid=%b data=%h required 1/%h",
                     bus.m_valid_o, bus.m_data_o, xbeat(mkh(20), 0));
        end
        drain(20, 36, "t4");
        checks++;
        if (bus.hash_count_o !== 16'd9 || bus.level_o !== '0 || bus.m_valid_o !== 1'b0
            || bus.drop_count_o !== 16'd2) begin
            errors++;
            $display("FAIL t4_end hc=%0d level=%0d valid=%b dc=%0d required 9/0/0/2",
                     bus.hash_count_o, bus.level_o, bus.m_valid_o, bus.drop_count_o);
        end
    endtask

    task automatic test_full_pop();
        bit found;
        found = 1'b0;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            bus.hash_valid_i = 1'b1;
            bus.hash_i = mkh(40 + c);
            @(negedge clk);
        end
        bus.hash_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.level_o !== 4'd8 || bus.drop_count_o !== '0) begin
            errors++;
            $display("FAIL t5_fill level=%0d dc=%0d required 8/0",
                     bus.level_o, bus.drop_count_o);
        end
        bus.m_ready_i = 1'b1;
        for (int c = 0; c < 12 && !found; c++) begin
            if (bus.m_valid_o === 1'b1 && bus.m_last_o === 1'b1) begin
                found = 1'b1;
                bus.hash_valid_i = 1'b1;
                bus.hash_i = mkh(49);
            end
            @(negedge clk);
        end
        bus.hash_valid_i = 1'b0;
        checks++;
        if (!found || bus.drop_count_o !== '0 || bus.level_o !== 4'd8
            || bus.overflow_o !== 1'b0 || bus.hash_count_o !== 16'd1) begin
            errors++;
            $display("FAIL t5_pop found=%b dc=%0d level=%0d ovf=%b hc=%0d required 1/0/8/0/1",
                     found, bus.drop_count_o, bus.level_o, bus.overflow_o, bus.hash_count_o);
        end
        drain(41, 36, "t5");
        checks++;
        if (bus.hash_count_o !== 16'd10 || bus.level_o !== '0) begin
            errors++;
            $display("FAIL t5_end hc=%0d level=%0d required 10/0",
                     bus.hash_count_o, bus.level_o);
        end
    endtask

    task automatic test_reset_mid_hash();
        int n;
        bit stale;
        n = 0;
        stale = 1'b0;
        do_reset();
        bus.m_ready_i = 1'b1;
        bus.hash_valid_i = 1'b1;
        bus.hash_i = mkh(60);
        @(negedge clk);
        bus.hash_i = mkh(61);
        @(negedge clk);
        bus.hash_valid_i = 1'b0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            if (bus.m_valid_o === 1'b1) n++;
            if (n < 3) @(negedge clk);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.m_valid_o !== 1'b0 || bus.m_last_o !== 1'b0 || bus.m_data_o !== '0
            || bus.level_o !== '0 || bus.hash_count_o !== '0 || bus.drop_count_o !== '0
            || bus.overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL t6_async valid=%b last=%b data=%h level=%0d hc=%0d required zeros",
                     bus.m_valid_o, bus.m_last_o, bus.m_data_o, bus.level_o, bus.hash_count_o);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.m_valid_o !== 1'b0 || bus.level_o !== '0) stale = 1'b1;
        end
        checks++;
        if (stale || bus.hash_count_o !== '0) begin
            errors++;
            $display("FAIL t6_stale stale=%b hc=%0d required 0/0", stale, bus.hash_count_o);
        end
        bus.hash_valid_i = 1'b1;
        bus.hash_i = mkh(70);
        @(negedge clk);
        bus.hash_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== xbeat(mkh(70), 0)) begin
            errors++;
            $display("FAIL t6_fresh valid=%b data=%h required 1/%h",
                     bus.m_valid_o, bus.m_data_o, xbeat(mkh(70), 0));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid_hash();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
